// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver: frame states,
// scan-code prefixes, HID usage codes and the scan-code to HID translation.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;

    localparam logic [7:0] HID_NONE  = 8'h00;
    localparam logic [7:0] HID_A     = 8'h04;
    localparam logic [7:0] HID_D     = 8'h07;
    localparam logic [7:0] HID_M     = 8'h10;
    localparam logic [7:0] HID_S     = 8'h16;
    localparam logic [7:0] HID_W     = 8'h1A;
    localparam logic [7:0] HID_ENTER = 8'h28;
    localparam logic [7:0] HID_SPACE = 8'h2C;
    localparam logic [7:0] HID_RIGHT = 8'h4F;
    localparam logic [7:0] HID_LEFT  = 8'h50;
    localparam logic [7:0] HID_DOWN  = 8'h51;
    localparam logic [7:0] HID_UP    = 8'h52;

    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{par, data};
    endfunction

    function automatic logic [7:0] ps2_to_hid(input logic ext, input logic [7:0] code);
        logic [7:0] hid;
        case ({ext, code})
            9'h01C:  hid = HID_A;
            9'h023:  hid = HID_D;
            9'h01B:  hid = HID_S;
            9'h01D:  hid = HID_W;
            9'h029:  hid = HID_SPACE;
            9'h03A:  hid = HID_M;
            9'h05A:  hid = HID_ENTER;
            9'h175:  hid = HID_UP;
            9'h172:  hid = HID_DOWN;
            9'h16B:  hid = HID_LEFT;
            9'h174:  hid = HID_RIGHT;
            default: hid = HID_NONE;
        endcase
        return hid;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: pin synchronisers, falling-edge detect, 11-bit frame
// FSM with odd parity and stop-bit check, and a mid-frame inactivity timeout.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err
);

    localparam int              CW      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(TIMEOUT_CYC - 1);

    logic               r_clk_meta, r_clk_sync, r_clk_prev;
    logic               r_dat_meta, r_dat_sync;
    logic               w_fall;
    frame_state_t       r_state;
    logic [2:0]         r_bit_cnt;
    logic [7:0]         r_shift;
    logic               r_par_ok;
    logic [CW-1:0]      r_idle_cnt;

    // Two-flop synchronisers; reset to the idle-high bus level so no false edge appears.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_clk_meta <= 1'b1;
            r_clk_sync <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_meta <= 1'b1;
            r_dat_sync <= 1'b1;
        end else begin
            r_clk_meta <= i_ps2_clk;
            r_clk_sync <= r_clk_meta;
            r_clk_prev <= r_clk_sync;
            r_dat_meta <= i_ps2_dat;
            r_dat_sync <= r_dat_meta;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_sync;

    // Frame FSM with timeout; byte_valid and err are registered one-cycle pulses.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_par_ok     <= 1'b0;
            r_idle_cnt   <= '0;
            o_byte       <= 8'h00;
            o_byte_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_byte_valid <= 1'b0;
            o_err        <= 1'b0;
            if (r_state == IDLE) begin
                r_idle_cnt <= '0;
                if (w_fall && !r_dat_sync) begin
                    r_state   <= DATA;
                    r_bit_cnt <= 3'd0;
                end
            end else if (w_fall) begin
                r_idle_cnt <= '0;
                case (r_state)
                    DATA: begin
                        r_shift <= {r_dat_sync, r_shift[7:1]};
                        if (r_bit_cnt == 3'd7) begin
                            r_state <= PARITY;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        r_par_ok <= odd_parity_ok(r_shift, r_dat_sync);
                        r_state  <= STOP;
                    end
                    STOP: begin
                        if (r_dat_sync && r_par_ok) begin
                            o_byte       <= r_shift;
                            o_byte_valid <= 1'b1;
                        end else begin
                            o_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end else if (r_idle_cnt == CNT_MAX) begin
                r_state    <= IDLE;
                r_idle_cnt <= '0;
                o_err      <= 1'b1;
            end else begin
                r_idle_cnt <= r_idle_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/ps2_keycode_rx.sv
// PS/2 keyboard front end: decodes make/break prefixes, translates to HID
// usage codes and keeps a four-slot table of held keys for the game logic.
module ps2_keycode_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        PS2_CLK,
    input  logic        PS2_DAT,
    output logic [31:0] keycode,
    output logic        key_event,
    output logic        frame_err
);

    logic [7:0]         w_byte;
    logic               w_byte_valid;
    logic               w_err;
    logic [7:0]         w_hid;
    logic [3:0]         w_match, w_empty;
    logic               w_hit, w_free;
    logic [1:0]         w_hit_idx, w_free_idx;
    logic               r_ext, r_brk, r_key_event;
    logic [3:0][7:0]    r_slots;

    ps2_frame_rx #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_frame_rx (
        .i_clk        (Clk),
        .i_rst_n      (Reset_n),
        .i_ps2_clk    (PS2_CLK),
        .i_ps2_dat    (PS2_DAT),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_err        (w_err)
    );

    // Slot lookup: where the translated key already sits and the lowest free slot.
    always_comb begin
        w_hid = ps2_to_hid(r_ext, w_byte);
        for (int i = 0; i < 4; i++) begin
            w_match[i] = (r_slots[i] == w_hid);
            w_empty[i] = (r_slots[i] == HID_NONE);
        end
        w_hit  = |w_match;
        w_free = |w_empty;
        if (w_match[0])      w_hit_idx = 2'd0;
        else if (w_match[1]) w_hit_idx = 2'd1;
        else if (w_match[2]) w_hit_idx = 2'd2;
        else                 w_hit_idx = 2'd3;
        if (w_empty[0])      w_free_idx = 2'd0;
        else if (w_empty[1]) w_free_idx = 2'd1;
        else if (w_empty[2]) w_free_idx = 2'd2;
        else                 w_free_idx = 2'd3;
    end

    // Prefix flags and slot table; a slot is never moved once written.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_ext       <= 1'b0;
            r_brk       <= 1'b0;
            r_slots     <= '0;
            r_key_event <= 1'b0;
        end else begin
            r_key_event <= 1'b0;
            if (w_err) begin
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end else if (w_byte_valid) begin
                if (w_byte == PS2_EXT) begin
                    r_ext <= 1'b1;
                end else if (w_byte == PS2_BRK) begin
                    r_brk <= 1'b1;
                end else begin
                    r_ext <= 1'b0;
                    r_brk <= 1'b0;
                    if (w_hid != HID_NONE) begin
                        if (r_brk) begin
                            if (w_hit) begin
                                r_slots[w_hit_idx] <= HID_NONE;
                                r_key_event        <= 1'b1;
                            end
                        end else if (!w_hit && w_free) begin
                            r_slots[w_free_idx] <= w_hid;
                            r_key_event         <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign keycode   = r_slots;
    assign key_event = r_key_event;
    assign frame_err = w_err;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// Directed plus randomized frames against a table-driven model of the
// held-key set, with pulse-width and keycode/key_event coherence monitors.
module tb_ps2_keycode_rx;

    localparam int TO   = 1000;
    localparam int HALF = 20;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        PS2_CLK = 1'b1;
    logic        PS2_DAT = 1'b1;
    logic [31:0] keycode;
    logic        key_event, frame_err;

    int vectors = 0, miscompares = 0;
    int ev_cnt = 0, err_cnt = 0, wide_cnt = 0, sync_bad = 0;
    int exp_ev = 0, exp_err = 0;
    logic        prev_ke = 1'b0, prev_fe = 1'b0, prev_rst = 1'b0;
    logic [31:0] prev_kc = 32'h0;

    logic [7:0]  m_slot [4];
    bit          m_ext, m_brk;

    logic [8:0]  map_key [11] = '{9'h01C, 9'h023, 9'h01B, 9'h01D, 9'h029, 9'h03A,
                                  9'h05A, 9'h175, 9'h172, 9'h16B, 9'h174};
    logic [7:0]  map_hid [11] = '{8'h04, 8'h07, 8'h16, 8'h1A, 8'h2C, 8'h10,
                                  8'h28, 8'h52, 8'h51, 8'h50, 8'h4F};
    logic [7:0]  pool [14] = '{8'hE0, 8'hF0, 8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29,
                               8'h3A, 8'h5A, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h00};

    ps2_keycode_rx #(.TIMEOUT_CYC(TO)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .PS2_CLK   (PS2_CLK),
        .PS2_DAT   (PS2_DAT),
        .keycode   (keycode),
        .key_event (key_event),
        .frame_err (frame_err)
    );

    always #10 Clk = ~Clk;

    // Pulse counting, width checks and keycode-change/key_event coherence.
    always @(negedge Clk) begin
        if (key_event) ev_cnt++;
        if (frame_err) err_cnt++;
        if ((key_event && prev_ke) || (frame_err && prev_fe)) wide_cnt++;
        if (Reset_n && prev_rst && ((keycode != prev_kc) != key_event)) sync_bad++;
        prev_ke  = key_event;
        prev_fe  = frame_err;
        prev_kc  = keycode;
        prev_rst = Reset_n;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] ref_hid(input bit ext, input logic [7:0] c);
        for (int i = 0; i < 11; i++)
            if (map_key[i] == {ext, c}) return map_hid[i];
        return 8'h00;
    endfunction

    function automatic logic [31:0] model_kc();
        return {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_slot[i] = 8'h00;
        m_ext = 1'b0;
        m_brk = 1'b0;
    endtask

    task automatic model_err();
        m_ext = 1'b0;
        m_brk = 1'b0;
        exp_err++;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [7:0] h;
        int         pos, free;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            h = ref_hid(m_ext, b);
            pos = -1;
            free = -1;
            for (int i = 3; i >= 0; i--) begin
                if (m_slot[i] == h) pos = i;
                if (m_slot[i] == 8'h00) free = i;
            end
            if (h != 8'h00) begin
                if (m_brk && pos >= 0) begin
                    m_slot[pos] = 8'h00;
                    exp_ev++;
                end else if (!m_brk && pos < 0 && free >= 0) begin
                    m_slot[free] = h;
                    exp_ev++;
                end
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            PS2_DAT = bits[i];
            repeat (HALF) @(posedge Clk);
            PS2_CLK = 1'b0;
            repeat (HALF) @(posedge Clk);
            PS2_CLK = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^b) ^ bad_par;
        send_bits({~bad_stop, par, b, 1'b0}, 11);
        PS2_DAT = 1'b1;
        repeat (HALF) @(posedge Clk);
        if (bad_par || bad_stop) model_err();
        else model_byte(b);
    endtask

    task automatic check_state(input string tag);
        @(negedge Clk);
        chk({tag, "_keycode"}, keycode, model_kc());
        chk({tag, "_events"}, ev_cnt, exp_ev);
        chk({tag, "_errors"}, err_cnt, exp_err);
    endtask

    task automatic send_chk(input logic [7:0] b, input string tag);
        send_frame(b, 1'b0, 1'b0);
        check_state(tag);
    endtask

    initial begin
        logic [7:0] b;
        model_reset();
        repeat (5) @(posedge Clk);
        @(negedge Clk);
        chk("reset_keycode", keycode, 32'h0);
        chk("reset_key_event", key_event, 32'h0);
        chk("reset_frame_err", frame_err, 32'h0);
        Reset_n = 1'b1;
        repeat (5) @(posedge Clk);

        send_chk(8'h1C, "a_make");
        chk("a_make_const", keycode, 32'h0000_0004);
        send_chk(8'hF0, "a_brk_prefix");
        send_chk(8'h1C, "a_break");
        chk("a_break_const", keycode, 32'h0000_0000);
        chk("a_two_events", ev_cnt, 32'd2);

        send_chk(8'h1D, "fill_w");
        send_chk(8'h1B, "fill_s");
        send_chk(8'h23, "fill_d");
        send_chk(8'h1C, "fill_a");
        send_chk(8'h29, "full_drop");
        chk("full_const", keycode, 32'h0407_161A);

        send_chk(8'hF0, "s_prefix");
        send_chk(8'h1B, "s_break");
        chk("hole_const", keycode, 32'h0407_001A);
        send_chk(8'h29, "space_fill");
        chk("no_compact_const", keycode, 32'h0407_2C1A);

        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h1C, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h23, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0); send_frame(8'h29, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b0, 1'b0); send_chk(8'h1D, "release_all");

        send_frame(8'hE0, 1'b0, 1'b0); send_chk(8'h75, "up_make");
        chk("up_const", keycode, 32'h0000_0052);
        send_frame(8'hE0, 1'b0, 1'b0); send_frame(8'hF0, 1'b0, 1'b0);
        send_chk(8'h75, "up_break");
        send_chk(8'h1C, "repeat1");
        send_chk(8'h1C, "repeat2");
        send_chk(8'h1C, "repeat3");
        send_frame(8'hF0, 1'b0, 1'b0); send_chk(8'h1C, "repeat_release");

        send_frame(8'h1C, 1'b1, 1'b0);
        check_state("bad_parity");
        send_frame(8'h1C, 1'b0, 1'b1);
        check_state("bad_stop");
        send_frame(8'hE0, 1'b0, 1'b0);
        send_frame(8'h75, 1'b1, 1'b0);
        send_chk(8'h75, "ext_cleared_by_err");
        send_bits(11'b000_0000_0110, 3);
        PS2_DAT = 1'b1;
        repeat (TO + 50) @(posedge Clk);
        model_err();
        check_state("timeout");
        send_chk(8'h1C, "after_timeout");
        chk("after_timeout_const", keycode, 32'h0000_0004);

        send_chk(8'h1D, "pre_reset");
        chk("pre_reset_const", keycode, 32'h0000_1A04);
        send_bits(11'b000_0010_1100, 4);
        PS2_CLK = 1'b0;
        repeat (5) @(posedge Clk);
        Reset_n = 1'b0;
        #1;
        chk("midframe_rst_keycode", keycode, 32'h0);
        chk("midframe_rst_key_event", key_event, 32'h0);
        chk("midframe_rst_frame_err", frame_err, 32'h0);
        model_reset();
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        repeat (10) @(posedge Clk);
        Reset_n = 1'b1;
        repeat (10) @(posedge Clk);
        send_chk(8'h23, "post_reset_d");
        chk("post_reset_const", keycode, 32'h0000_0007);

        for (int n = 0; n < 60; n++) begin
            b = pool[$urandom_range(0, 13)];
            if (b == 8'h00) b = 8'($urandom_range(0, 255));
            case ($urandom_range(0, 9))
                0:       send_frame(b, 1'b1, 1'b0);
                1:       send_frame(b, 1'b0, 1'b1);
                default: send_frame(b, 1'b0, 1'b0);
            endcase
            check_state("random");
        end

        chk("pulse_width", wide_cnt, 32'd0);
        chk("event_coherence", sync_bad, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
